// File: rtl/vigna_intc.sv
// vigna_intc: NUM_SRC-source interrupt controller with enable, priority, threshold and claim/complete.
// Ports: clk, reset (sync, active-high), src_irq, s_* data-bus slave, ext_irq. Option: VIGNA_INTC_EDGE_EN.
module vigna_intc #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_addr,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  output logic [31:0]        s_rdata,
  output logic               ext_irq
);

  typedef enum logic [1:0] {IDLE, RESP, DRAIN} state_t;

  state_t            state, state_n;
  logic [NUM_SRC:1]  sync1, sync2;
  logic [NUM_SRC:1]  pending, in_service, enable;
  logic [NUM_SRC:1]  gw_set, claim_mask, cmpl_mask;
  logic [PRIO_W-1:0] prio [1:NUM_SRC];
  logic [PRIO_W-1:0] threshold, best_p;
  logic [4:0]        best_id, best_n;
  logic [31:0]       rdata_q, rd_val;
  logic [5:0]        word;
  logic              accept, is_wr;
`ifdef VIGNA_INTC_EDGE_EN
  logic [NUM_SRC:1]  sync3, mode;
`endif

  assign word   = s_addr[7:2];
  assign accept = (state == IDLE) && s_valid;
  assign is_wr  = |s_wstrb;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (s_valid) state_n = RESP;
      RESP:    state_n = DRAIN;
      DRAIN:   if (!s_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == RESP);
    s_rdata = (state == RESP) ? rdata_q : '0;
  end

  // Starting from threshold makes "prio > THRESHOLD" implicit;
  // ascending scan with strict > keeps the lowest ID on ties.
  always_comb begin
    best_n = '0;
    best_p = threshold;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pending[i] && !in_service[i] && enable[i] &&
          prio[i] > best_p) begin
        best_p = prio[i];
        best_n = 5'(i);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (word)
      6'd0: rd_val[NUM_SRC:0] = {pending, 1'b0};
      6'd1: rd_val[NUM_SRC:0] = {enable, 1'b0};
      6'd2: rd_val[PRIO_W-1:0] = threshold;
      6'd3: rd_val[4:0] = best_id;
`ifdef VIGNA_INTC_EDGE_EN
      6'd4: rd_val[NUM_SRC:0] = {mode, 1'b0};
`endif
      default: ;
    endcase
    for (int i = 1; i <= NUM_SRC; i++)
      if (word == 6'(16 + i)) rd_val[PRIO_W-1:0] = prio[i];
  end

  always_comb begin
    for (int i = 1; i <= NUM_SRC; i++) begin
      claim_mask[i] = accept && !is_wr && word == 6'd3 &&
                      best_id == 5'(i);
      cmpl_mask[i]  = accept && is_wr && word == 6'd3 &&
                      s_wdata[4:0] == 5'(i);
`ifdef VIGNA_INTC_EDGE_EN
      // Edge sources latch one event even while in service.
      gw_set[i] = mode[i] ? (sync2[i] && !sync3[i]) :
                  (sync2[i] && !pending[i] && !in_service[i]);
`else
      gw_set[i] = sync2[i] && !pending[i] && !in_service[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      pending    <= '0;
      in_service <= '0;
      enable     <= '0;
      threshold  <= '0;
      best_id    <= '0;
      ext_irq    <= 1'b0;
      rdata_q    <= '0;
      for (int i = 1; i <= NUM_SRC; i++) prio[i] <= '0;
`ifdef VIGNA_INTC_EDGE_EN
      sync3      <= '0;
      mode       <= '0;
`endif
    end else begin
      sync1      <= src_irq;
      sync2      <= sync1;
      // Claim clears after the gateway set, so claim wins.
      pending    <= (pending | gw_set) & ~claim_mask;
      in_service <= (in_service | claim_mask) & ~cmpl_mask;
      best_id    <= best_n;
      ext_irq    <= (best_n != '0);
`ifdef VIGNA_INTC_EDGE_EN
      sync3      <= sync2;
`endif
      if (accept) rdata_q <= is_wr ? '0 : rd_val;
      if (accept && is_wr) begin
        if (word == 6'd1) enable <= s_wdata[NUM_SRC:1];
        if (word == 6'd2) threshold <= s_wdata[PRIO_W-1:0];
`ifdef VIGNA_INTC_EDGE_EN
        if (word == 6'd4) mode <= s_wdata[NUM_SRC:1];
`endif
        for (int i = 1; i <= NUM_SRC; i++)
          if (word == 6'(16 + i)) prio[i] <= s_wdata[PRIO_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_vigna_intc.sv
// tb_vigna_intc: directed and random stimulus for vigna_intc,
// checked each cycle against a behavioural model.
module tb_vigna_intc;
  localparam int N  = 8;
  localparam int PW = 3;

  logic         clk = 0;
  logic         reset = 1;
  logic [N-1:0] src_irq = '0;
  logic         s_valid = 0;
  logic         s_ready;
  logic [7:0]   s_addr = '0;
  logic [31:0]  s_wdata = '0;
  logic [3:0]   s_wstrb = '0;
  logic [31:0]  s_rdata;
  logic         ext_irq;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  vigna_intc #(.NUM_SRC(N), .PRIO_W(PW)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .ext_irq(ext_irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit          mp [1:N];
  bit          ms [1:N];
  bit          me [1:N];
  bit          mmode [1:N];
  int          mpr [1:N];
  int          mthr, mbest, phase;
  bit          mext;
  logic [31:0] mrd;
  bit          h1 [1:N];
  bit          h2 [1:N];
  bit          h3 [1:N];

  function automatic int arb();
    int b, bp;
    b = 0;
    bp = mthr;
    for (int i = 1; i <= N; i++)
      if (mp[i] && !ms[i] && me[i] && mpr[i] > bp) begin
        bp = mpr[i];
        b = i;
      end
    return b;
  endfunction

  function automatic logic [31:0] mread(int w);
    logic [31:0] r;
    r = '0;
    for (int i = 1; i <= N; i++) begin
      if (w == 0) r[i] = mp[i];
      if (w == 1) r[i] = me[i];
`ifdef VIGNA_INTC_EDGE_EN
      if (w == 4) r[i] = mmode[i];
`endif
      if (w == 16 + i) r = mpr[i];
    end
    if (w == 2) r = mthr;
    if (w == 3) r = mbest;
    return r;
  endfunction

  always @(posedge clk) begin
    int nb, w, cid, pid;
    bit acc, wr;
    bit setv [1:N];
    started = 1;
    if (reset) begin
      for (int i = 1; i <= N; i++) begin
        mp[i] = 0; ms[i] = 0; me[i] = 0; mpr[i] = 0;
        mmode[i] = 0; h1[i] = 0; h2[i] = 0; h3[i] = 0;
      end
      mthr = 0; mbest = 0; mext = 0; phase = 0; mrd = '0;
    end else begin
      nb  = arb();
      acc = (phase == 0) && s_valid;
      wr  = (s_wstrb != 0);
      w   = int'(s_addr[7:2]);
      cid = 0;
      for (int i = 1; i <= N; i++)
        setv[i] = mmode[i] ? (h2[i] && !h3[i])
                           : (h2[i] && !mp[i] && !ms[i]);
      if (acc) begin
        mrd = wr ? '0 : mread(w);
        if (wr) begin
          if (w == 1) for (int i = 1; i <= N; i++) me[i] = s_wdata[i];
          if (w == 2) mthr = int'(s_wdata[PW-1:0]);
`ifdef VIGNA_INTC_EDGE_EN
          if (w == 4) for (int i = 1; i <= N; i++) mmode[i] = s_wdata[i];
`endif
          if (w == 3) begin
            pid = int'(s_wdata[4:0]);
            if (pid >= 1 && pid <= N) ms[pid] = 0;
          end
          if (w > 16 && w <= 16 + N) mpr[w-16] = int'(s_wdata[PW-1:0]);
        end else if (w == 3) begin
          cid = mbest;
        end
      end
      for (int i = 1; i <= N; i++) begin
        if (setv[i]) mp[i] = 1;
        if (cid == i) begin mp[i] = 0; ms[i] = 1; end
      end
      case (phase)
        0: if (acc) phase = 1;
        1: phase = 2;
        default: if (!s_valid) phase = 0;
      endcase
      mbest = nb;
      mext  = (nb != 0);
      for (int i = 1; i <= N; i++) begin
        h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = src_irq[i-1];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("ext_irq", {31'b0, ext_irq}, {31'b0, mext});
      chk("s_ready", {31'b0, s_ready}, {31'b0, phase == 1});
      chk("s_rdata", s_rdata, (phase == 1) ? mrd : '0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [7:0] a, input logic [31:0] d,
                     input bit wr, output logic [31:0] r);
    bit got;
    got = 0;
    r = '0;
    @(posedge clk); #1;
    s_addr = a; s_wdata = d; s_wstrb = wr ? 4'hF : 4'h0;
    s_valid = 1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (s_ready) begin got = 1; r = s_rdata; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL bus_timeout addr=%h got=no_ready exp=ready", a);
    end
    @(posedge clk); #1;
    s_valid = 0; s_wstrb = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, d, 1, r);
  endtask

  task automatic rdc(input string nm, input logic [7:0] a,
                     input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 32'h0, 0, r);
    chk(nm, r, exp);
  endtask

  task automatic do_reset();
    src_irq = '0;
    reset = 1;
    cyc(3);
    reset = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    cyc(1);
    do_reset();
    chk("rst_ext", {31'b0, ext_irq}, 32'h0);
    chk("rst_rdy", {31'b0, s_ready}, 32'h0);
    rdc("rst_pend", 8'h00, 32'h0);
    rdc("rst_en", 8'h04, 32'h0);
    rdc("rst_thr", 8'h08, 32'h0);
    rdc("rst_claim", 8'h0C, 32'h0);

    wr(8'h04, 32'h4);
    wr(8'h48, 32'h1);
    src_irq = 8'h02;
    cyc(3);
    chk("lat3", {31'b0, ext_irq}, 32'h0);
    cyc(1);
    chk("lat4", {31'b0, ext_irq}, 32'h1);
    src_irq = '0;
    rdc("claim2", 8'h0C, 32'h2);
    chk("drop", {31'b0, ext_irq}, 32'h0);
    wr(8'h0C, 32'h2);

    do_reset();
    wr(8'h4C, 32'h5);
    wr(8'h54, 32'h5);
    wr(8'h58, 32'h7);
    wr(8'h04, 32'h68);
    src_irq = 8'h34;
    cyc(3);
    src_irq = '0;
    cyc(4);
    rdc("claim6", 8'h0C, 32'h6);
    wr(8'h0C, 32'h6);
    rdc("claim3", 8'h0C, 32'h3);
    rdc("claim5", 8'h0C, 32'h5);
    rdc("claim0", 8'h0C, 32'h0);

    do_reset();
    wr(8'h44, 32'h2);
    wr(8'h08, 32'h2);
    wr(8'h04, 32'h2);
    src_irq = 8'h01;
    cyc(8);
    chk("thr_block", {31'b0, ext_irq}, 32'h0);
    wr(8'h08, 32'h1);
    chk("thr_open", {31'b0, ext_irq}, 32'h1);
    rdc("claim1", 8'h0C, 32'h1);
    cyc(1);
    chk("insvc_quiet", {31'b0, ext_irq}, 32'h0);
    wr(8'h0C, 32'h4);
    rdc("cmpl4_pend", 8'h00, 32'h0);
    chk("cmpl4_ext", {31'b0, ext_irq}, 32'h0);
    wr(8'h0C, 32'h1);
    cyc(2);
    chk("repend", {31'b0, ext_irq}, 32'h1);
    rdc("reclaim1", 8'h0C, 32'h1);
    src_irq = '0;
    wr(8'h0C, 32'h1);

`ifdef VIGNA_INTC_EDGE_EN
    do_reset();
    wr(8'h10, 32'h2);
    wr(8'h44, 32'h1);
    wr(8'h04, 32'h2);
    src_irq = 8'h01; cyc(1); src_irq = '0;
    cyc(5);
    rdc("e_claim1", 8'h0C, 32'h1);
    repeat (2) begin
      src_irq = 8'h01; cyc(2); src_irq = '0; cyc(3);
    end
    wr(8'h0C, 32'h1);
    cyc(3);
    rdc("e_claim1b", 8'h0C, 32'h1);
    wr(8'h0C, 32'h1);
    cyc(4);
    rdc("e_claim0", 8'h0C, 32'h0);
`endif

    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) src_irq = N'($urandom);
      case ($urandom_range(0, 7))
        0: wr(8'h04, $urandom);
        1: wr(8'h08, $urandom);
        2: wr(8'(8'h40 + 4 * $urandom_range(0, N + 1)), $urandom);
        3, 4: bus(8'h0C, 32'h0, 0, r);
        5: wr(8'h0C, ($urandom_range(0, 1) == 1) ?
              32'($urandom_range(1, N)) : 32'($urandom_range(0, 31)));
        6: bus(8'($urandom), $urandom, $urandom_range(0, 3) == 0, r);
        default: cyc($urandom_range(1, 4));
      endcase
    end
    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
